mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous RAM between the core's instruction-fetch port and its data (load/store) port.
- Arbitrates per cycle, issues at most one RAM access per cycle, and routes read data back to the owning requester one cycle later.
- Sits between the core's fetch/memory interfaces and the unified RAM. This lets the design move from separate instruction/data memories to a single memory.

---
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and unified-RAM signals around mem_port_arbiter.
// The slave modport is the arbiter's view; master is the environment's view
// (core request/response ports plus the RAM read-data return).
interface mem_port_arbiter_if #(
  parameter int XLEN = 32
);
  logic            if_req_valid;
  logic            if_req_ready;
  logic [XLEN-1:0] if_req_addr;
  logic            if_rsp_valid;
  logic [XLEN-1:0] if_rsp_data;

  logic            d_req_valid;
  logic            d_req_ready;
  logic            d_req_we;
  logic [XLEN-1:0] d_req_addr;
  logic [XLEN-1:0] d_req_wdata;
  logic            d_rsp_valid;
  logic [XLEN-1:0] d_rsp_data;

  logic            mem_en;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  if_req_valid, if_req_addr,
    input  d_req_valid, d_req_we, d_req_addr, d_req_wdata,
    input  mem_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req_valid, if_req_addr,
    output d_req_valid, d_req_we, d_req_addr, d_req_wdata,
    output mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between the
// instruction-fetch port and the data port. One access per cycle; read data
// is steered back to the owning port one cycle after the grant.
//
// Build option MEM_ARB_ROUND_ROBIN_EN:
//   undefined - data port has priority; a fetch that has lost MAX_WAIT
//               consecutive cycles is forced to win the next conflict.
//   defined   - conflicts alternate between the ports (data wins the first).
module mem_port_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4
) (
  input logic               clk,
  input logic               n_rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_e;

  logic   grant_if_s;
  logic   grant_d_s;
  logic   conflict_s;

  logic   if_rsp_valid_r;
  logic   d_rsp_valid_r;
  logic   rsp_store_r;
  owner_e rsp_owner_r;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_e last_winner_r;
`else
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
  logic [3:0] wait_cnt_r;
`endif

  assign conflict_s = bus.if_req_valid && bus.d_req_valid;

  // Per-cycle grant decision; nothing is granted while reset is asserted.
  always_comb begin
    grant_if_s = 1'b0;
    grant_d_s  = 1'b0;
    if (!n_rst) begin
      grant_if_s = 1'b0;
      grant_d_s  = 1'b0;
    end else if (conflict_s) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (last_winner_r == OWNER_D) begin
        grant_if_s = 1'b1;
      end else begin
        grant_d_s = 1'b1;
      end
`else
      if (wait_cnt_r == MAX_WAIT_C) begin
        grant_if_s = 1'b1;
      end else begin
        grant_d_s = 1'b1;
      end
`endif
    end else if (bus.if_req_valid) begin
      grant_if_s = 1'b1;
    end else if (bus.d_req_valid) begin
      grant_d_s = 1'b1;
    end else begin
      grant_if_s = 1'b0;
      grant_d_s  = 1'b0;
    end
  end

  assign bus.if_req_ready = grant_if_s;
  assign bus.d_req_ready  = grant_d_s;

  // RAM command mux: granted port drives the RAM, idle cycles drive zeros.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {XLEN{1'b0}};
    bus.mem_wdata = {XLEN{1'b0}};
    case ({grant_if_s, grant_d_s})
      2'b10: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.if_req_addr;
      end
      2'b01: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.d_req_we;
        bus.mem_addr  = bus.d_req_addr;
        bus.mem_wdata = bus.d_req_wdata;
      end
      default: begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = {XLEN{1'b0}};
        bus.mem_wdata = {XLEN{1'b0}};
      end
    endcase
  end

  // Response pipeline: remember who was granted so the next cycle's RAM data
  // (or a store ack) goes to that port only.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      if_rsp_valid_r <= 1'b0;
      d_rsp_valid_r  <= 1'b0;
      rsp_store_r    <= 1'b0;
      rsp_owner_r    <= OWNER_IF;
    end else begin
      if_rsp_valid_r <= grant_if_s;
      d_rsp_valid_r  <= grant_d_s;
      rsp_store_r    <= grant_d_s && bus.d_req_we;
      if (grant_d_s) begin
        rsp_owner_r <= OWNER_D;
      end else if (grant_if_s) begin
        rsp_owner_r <= OWNER_IF;
      end else begin
        rsp_owner_r <= rsp_owner_r;
      end
    end
  end

  assign bus.if_rsp_valid = if_rsp_valid_r;
  assign bus.d_rsp_valid  = d_rsp_valid_r;

  // Read-data steering; the non-owner and store acks see zero.
  always_comb begin
    bus.if_rsp_data = {XLEN{1'b0}};
    bus.d_rsp_data  = {XLEN{1'b0}};
    if (if_rsp_valid_r && (rsp_owner_r == OWNER_IF)) begin
      bus.if_rsp_data = bus.mem_rdata;
    end else if (d_rsp_valid_r && (rsp_owner_r == OWNER_D) && !rsp_store_r) begin
      bus.d_rsp_data = bus.mem_rdata;
    end else begin
      bus.if_rsp_data = {XLEN{1'b0}};
      bus.d_rsp_data  = {XLEN{1'b0}};
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Remember the winner of the latest conflict; uncontested grants leave it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      last_winner_r <= OWNER_IF;
    end else if (conflict_s && grant_d_s) begin
      last_winner_r <= OWNER_D;
    end else if (conflict_s && grant_if_s) begin
      last_winner_r <= OWNER_IF;
    end else begin
      last_winner_r <= last_winner_r;
    end
  end
`else
  // Starvation guard: count consecutive cycles a pending fetch is refused.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wait_cnt_r <= 4'd0;
    end else if (!bus.if_req_valid || grant_if_s) begin
      wait_cnt_r <= 4'd0;
    end else if (wait_cnt_r != MAX_WAIT_C) begin
      wait_cnt_r <= wait_cnt_r + 4'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a RAM model, a behavioural
// reference of the arbitration rules, directed scenarios and random traffic.
module tb_mem_port_arbiter;
  localparam int XLEN     = 32;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.XLEN(XLEN)) bus ();

  mem_port_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Power-on contents of the RAM, identical for RAM and model.
  function automatic logic [31:0] ram_init(input int i);
    return 32'h0050_0093 + 32'(i - 4) * 32'h0001_0100;
  endfunction

  // Synchronous single-port RAM, 64 words, indexed by byte address [7:2].
  logic [31:0] ram [0:63];
  bit          ram_written [0:63];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr[7:2]]         <= bus.mem_wdata;
        ram_written[bus.mem_addr[7:2]] <= 1'b1;
      end else begin
        bus.mem_rdata <= ram_written[bus.mem_addr[7:2]] ? ram[bus.mem_addr[7:2]]
                                                        : ram_init(int'(bus.mem_addr[7:2]));
      end
    end
  end

  // Reference-model state
  logic [31:0] model_mem [0:63];
  int          m_wait;
  bit          m_last_d;
  bit          p_valid, p_is_if;
  logic [31:0] p_data;
  bit          if_acc, d_acc;
  logic [1:0]  grant_log [$];   // 0 none, 1 fetch, 2 data

  // Compare process: every falling edge, check DUT against the model.
  initial begin
    bit gi, gd;
    logic [31:0] e_addr, e_wdata;
    logic e_we;
    for (int i = 0; i < 64; i++) model_mem[i] = ram_init(i);
    m_wait = 0; m_last_d = 1'b0; p_valid = 1'b0; p_is_if = 1'b0; p_data = 32'h0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        check("rst_if_ready", {31'h0, bus.if_req_ready}, 32'h0);
        check("rst_d_ready",  {31'h0, bus.d_req_ready},  32'h0);
        check("rst_mem_en",   {31'h0, bus.mem_en},       32'h0);
        check("rst_rsp_valid", {30'h0, bus.if_rsp_valid, bus.d_rsp_valid}, 32'h0);
        m_wait = 0; m_last_d = 1'b0; p_valid = 1'b0;
        if_acc = 1'b0; d_acc = 1'b0;
        grant_log.push_back(2'd0);
      end else begin
        // responses owed from the previous cycle
        check("if_rsp_valid", {31'h0, bus.if_rsp_valid}, {31'h0, p_valid && p_is_if});
        check("d_rsp_valid",  {31'h0, bus.d_rsp_valid},  {31'h0, p_valid && !p_is_if});
        if (p_valid && p_is_if) begin
          check("if_rsp_data", bus.if_rsp_data, p_data);
          check("d_rsp_data_nonowner", bus.d_rsp_data, 32'h0);
        end else if (p_valid) begin
          check("d_rsp_data", bus.d_rsp_data, p_data);
          check("if_rsp_data_nonowner", bus.if_rsp_data, 32'h0);
        end
        // this cycle's grant
        gi = 1'b0; gd = 1'b0;
        if (bus.if_req_valid && bus.d_req_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          gi = m_last_d;
          gd = !m_last_d;
          m_last_d = gd;
`else
          gi = (m_wait >= MAX_WAIT);
          gd = !gi;
`endif
        end else begin
          gi = bus.if_req_valid;
          gd = bus.d_req_valid;
        end
        e_addr = gi ? bus.if_req_addr : (gd ? bus.d_req_addr : 32'h0);
        e_we   = gd ? bus.d_req_we : 1'b0;
        e_wdata = gd ? bus.d_req_wdata : 32'h0;
        check("if_req_ready", {31'h0, bus.if_req_ready}, {31'h0, gi});
        check("d_req_ready",  {31'h0, bus.d_req_ready},  {31'h0, gd});
        check("mem_en",       {31'h0, bus.mem_en},       {31'h0, gi || gd});
        check("mem_we",       {31'h0, bus.mem_we},       {31'h0, e_we});
        check("mem_addr",     bus.mem_addr,  e_addr);
        check("mem_wdata",    bus.mem_wdata, e_wdata);
        // what the next cycle must deliver
        p_valid = gi || gd;
        p_is_if = gi;
        if (gi) p_data = model_mem[bus.if_req_addr[7:2]];
        else if (gd && bus.d_req_we) begin
          p_data = 32'h0;
          model_mem[bus.d_req_addr[7:2]] = bus.d_req_wdata;
        end else if (gd) p_data = model_mem[bus.d_req_addr[7:2]];
        else p_data = 32'h0;
`ifndef MEM_ARB_ROUND_ROBIN_EN
        if (!bus.if_req_valid || gi) m_wait = 0;
        else if (m_wait < MAX_WAIT) m_wait++;
`endif
        if_acc = gi; d_acc = gd;
        grant_log.push_back(gi ? 2'd1 : (gd ? 2'd2 : 2'd0));
      end
    end
  end

  task automatic idle_inputs();
    bus.if_req_valid = 1'b0; bus.if_req_addr = 32'h0;
    bus.d_req_valid = 1'b0; bus.d_req_we = 1'b0;
    bus.d_req_addr = 32'h0; bus.d_req_wdata = 32'h0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic new_if();
    bus.if_req_valid = ($urandom_range(3) != 0);
    bus.if_req_addr  = {24'h0, 6'($urandom_range(63)), 2'b00};
  endtask

  task automatic new_d();
    bus.d_req_valid = ($urandom_range(3) != 0);
    bus.d_req_we    = ($urandom_range(1) == 1);
    bus.d_req_addr  = {24'h0, 6'($urandom_range(63)), 2'b00};
    bus.d_req_wdata = $urandom;
  endtask

  // Stimulus: directed scenarios then random traffic.
  initial begin
    int base;
    logic [1:0] exp_c [6];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_c = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
`else
    exp_c = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2};
`endif
    idle_inputs();
    n_rst = 1'b1;
    #2 n_rst = 1'b0;
    #1 check("reset_mem_en", {31'h0, bus.mem_en}, 32'h0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;

    // fetch only
    step(); bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h10;
    sample();
    check("fetch_mem_en", {31'h0, bus.mem_en}, 32'h1);
    check("fetch_mem_addr", bus.mem_addr, 32'h10);
    step(); idle_inputs();
    sample();
    check("fetch_rsp_valid", {31'h0, bus.if_rsp_valid}, 32'h1);
    check("fetch_rsp_data", bus.if_rsp_data, 32'h0050_0093);
    check("fetch_no_d_rsp", {31'h0, bus.d_rsp_valid}, 32'h0);

    // store then load
    step(); bus.d_req_valid = 1'b1; bus.d_req_we = 1'b1;
    bus.d_req_addr = 32'h40; bus.d_req_wdata = 32'hDEAD_BEEF;
    sample();
    check("store_mem_we", {31'h0, bus.mem_we}, 32'h1);
    step(); bus.d_req_we = 1'b0; bus.d_req_wdata = 32'h0;
    sample();
    check("store_ack_valid", {31'h0, bus.d_rsp_valid}, 32'h1);
    check("store_ack_data", bus.d_rsp_data, 32'h0);
    step(); idle_inputs();
    sample();
    check("load_valid", {31'h0, bus.d_rsp_valid}, 32'h1);
    check("load_data", bus.d_rsp_data, 32'hDEAD_BEEF);

    // conflict sequence from a clean reset
    step(); n_rst = 1'b0;
    step(); n_rst = 1'b1;
    step();
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h20;
    bus.d_req_valid = 1'b1; bus.d_req_we = 1'b0; bus.d_req_addr = 32'h44;
    base = grant_log.size();
    repeat (6) @(negedge clk);
    step(); idle_inputs();
    for (int k = 0; k < 6; k++)
      check($sformatf("conflict_grant%0d", k), {30'h0, grant_log[base + k]}, {30'h0, exp_c[k]});

    // back-to-back fetches
    step(); bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h0;
    step(); bus.if_req_addr = 32'h4;
    sample();
    check("b2b_word0", {bus.if_rsp_valid ? 1'b0 : 1'b1, 31'h0} ^ bus.if_rsp_data, 32'h004B_FC93);
    step(); bus.if_req_addr = 32'h8;
    sample();
    check("b2b_word1", {bus.if_rsp_valid ? 1'b0 : 1'b1, 31'h0} ^ bus.if_rsp_data, 32'h004C_FD93);
    step(); idle_inputs();
    sample();
    check("b2b_word2", {bus.if_rsp_valid ? 1'b0 : 1'b1, 31'h0} ^ bus.if_rsp_data, 32'h004D_FE93);

    // reset with a load in flight
    step(); bus.d_req_valid = 1'b1; bus.d_req_we = 1'b0; bus.d_req_addr = 32'h48;
    sample();
    check("midrst_grant", {31'h0, bus.d_req_ready}, 32'h1);
    step(); idle_inputs(); n_rst = 1'b0;
    sample();
    check("midrst_rsp_cleared", {31'h0, bus.d_rsp_valid}, 32'h0);
    step(); n_rst = 1'b1;
    repeat (3) begin
      sample();
      check("midrst_no_rsp", {30'h0, bus.if_rsp_valid, bus.d_rsp_valid}, 32'h0);
    end

    // random traffic, with one reset in the middle
    for (int c = 0; c < 500; c++) begin
      step();
      if (c == 250) n_rst = 1'b0;
      if (c == 252) n_rst = 1'b1;
      if (!bus.if_req_valid || if_acc) new_if();
      if (!bus.d_req_valid || d_acc) new_d();
    end
    step(); idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
